ac_control_unit: RTL and testbench

Fetch-decode-execute sequencer for the 12-bit accumulator processor. It drives load enables for AR, PC, DR, IR and AC, the shared-bus source select, the ALU operation code, and the memory read/write handshake. It decodes the IR opcode field and the AC zero flag, and produces no datapath values itself. A memory-wait watchdog halts the core with a sticky error if memory never acknowledges.

---
 rtl/ac_control_unit.sv | 198 +++++++++++++++++++
 tb/tb_ac_control_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ac_control_unit.sv
// Fetch-decode-execute sequencer for the 12-bit accumulator processor.
// Drives register strobes, bus select, ALU op and memory handshake; includes a memory-wait watchdog.
module ac_control_unit #(
  parameter int reg_width   = 12,
  parameter int OPCODE_W    = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [OPCODE_W-1:0] ir_op,
  input  logic                ac_zero,
  input  logic                mem_ready,
  output logic [2:0]          bus_sel,
  output logic                ar_we,
  output logic                pc_we,
  output logic                pc_inc,
  output logic                dr_we,
  output logic                ir_we,
  output logic                ac_we,
  output logic [2:0]          alu_op,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic                halted,
  output logic                illegal,
  output logic                bus_err,
  output logic [3:0]          state_dbg
);

  generate
    if (MEM_TIMEOUT < 1 || reg_width <= OPCODE_W) begin : g_bad_cfg
      $error("ac_control_unit: invalid parameter set");
    end
  endgenerate

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  localparam logic [OPCODE_W-1:0] OP_NOP  = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_LDA  = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_STA  = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_SUB  = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_AND  = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_JMP  = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_JZ   = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] OP_CLR  = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] OP_INC  = OPCODE_W'(9);
  localparam logic [OPCODE_W-1:0] OP_HALT = OPCODE_W'(15);

  localparam logic [2:0] BUS_NONE = 3'd0;
  localparam logic [2:0] BUS_PC   = 3'd1;
  localparam logic [2:0] BUS_DR   = 3'd2;
  localparam logic [2:0] BUS_AC   = 3'd3;
  localparam logic [2:0] BUS_IR   = 3'd4;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_INC  = 3'd4;
  localparam logic [2:0] ALU_ZERO = 3'd5;

  typedef enum logic [3:0] {
    IDLE = 4'd0, F0 = 4'd1, F1 = 4'd2, F2 = 4'd3, DEC = 4'd4,
    RD = 4'd5, EX = 4'd6, WR = 4'd7, HLT = 4'd8
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] wait_cnt, wait_cnt_next;
  logic          bus_err_next;
  logic          in_wait;
  logic          timeout;

  assign in_wait   = (state == F1) || (state == RD) || (state == WR);
  assign timeout   = !mem_ready && (wait_cnt == CW'(MEM_TIMEOUT - 1));
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      bus_err  <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      bus_err  <= bus_err_next;
    end
  end

  always_comb begin
    state_next    = state;
    wait_cnt_next = '0;
    bus_err_next  = bus_err;
    bus_sel       = BUS_NONE;
    alu_op        = ALU_PASS;
    ar_we         = 1'b0;
    pc_we         = 1'b0;
    pc_inc        = 1'b0;
    dr_we         = 1'b0;
    ir_we         = 1'b0;
    ac_we         = 1'b0;
    mem_rd        = 1'b0;
    mem_wr        = 1'b0;
    halted        = 1'b0;
    illegal       = 1'b0;

    case (state)
      IDLE: if (run) state_next = F0;
      F0: begin
        bus_sel    = BUS_PC;
        ar_we      = 1'b1;
        state_next = F1;
      end
      F1: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          dr_we      = 1'b1;
          pc_inc     = 1'b1;
          state_next = F2;
        end
      end
      F2: begin
        bus_sel    = BUS_DR;
        ir_we      = 1'b1;
        state_next = DEC;
      end
      DEC: begin
        state_next = F0;
        case (ir_op)
          OP_NOP: ;
          OP_LDA, OP_ADD, OP_SUB, OP_AND: begin
            bus_sel    = BUS_IR;
            ar_we      = 1'b1;
            state_next = RD;
          end
          OP_STA: begin
            bus_sel    = BUS_IR;
            ar_we      = 1'b1;
            state_next = WR;
          end
          OP_JMP: begin
            bus_sel = BUS_IR;
            pc_we   = 1'b1;
          end
          OP_JZ: begin
            bus_sel = BUS_IR;
            pc_we   = ac_zero;
          end
          OP_CLR: begin
            alu_op = ALU_ZERO;
            ac_we  = 1'b1;
          end
          OP_INC: begin
            alu_op = ALU_INC;
            ac_we  = 1'b1;
          end
          OP_HALT: state_next = HLT;
          default: illegal = 1'b1;
        endcase
      end
      RD: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          dr_we      = 1'b1;
          state_next = EX;
        end
      end
      EX: begin
        ac_we      = 1'b1;
        state_next = F0;
        case (ir_op)
          OP_ADD:  alu_op = ALU_ADD;
          OP_SUB:  alu_op = ALU_SUB;
          OP_AND:  alu_op = ALU_AND;
          default: alu_op = ALU_PASS;
        endcase
      end
      WR: begin
        bus_sel = BUS_AC;
        mem_wr  = 1'b1;
        if (mem_ready) state_next = F0;
      end
      HLT: halted = 1'b1;
      default: state_next = IDLE;
    endcase

    // Ready in the timeout cycle wins: only a still-unacknowledged request counts or trips.
    if (in_wait && !mem_ready) begin
      if (timeout) begin
        state_next   = HLT;
        bus_err_next = 1'b1;
      end else begin
        wait_cnt_next = wait_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ac_control_unit.sv
// Randomized scoreboard bench for ac_control_unit: an instruction-level model queues
// the expected per-cycle outputs, a monitor compares them at the falling edge.
module tb_ac_control_unit;
  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       reset, run, ac_zero, mem_ready;
  logic [3:0] ir_op;
  logic [2:0] bus_sel, alu_op;
  logic       ar_we, pc_we, pc_inc, dr_we, ir_we, ac_we;
  logic       mem_rd, mem_wr, halted, illegal, bus_err;
  logic [3:0] state_dbg;

  always #5 clk = ~clk;

  ac_control_unit #(.reg_width(12), .OPCODE_W(4), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .run(run), .ir_op(ir_op), .ac_zero(ac_zero),
    .mem_ready(mem_ready), .bus_sel(bus_sel), .ar_we(ar_we), .pc_we(pc_we),
    .pc_inc(pc_inc), .dr_we(dr_we), .ir_we(ir_we), .ac_we(ac_we), .alu_op(alu_op),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .halted(halted), .illegal(illegal),
    .bus_err(bus_err), .state_dbg(state_dbg)
  );

  typedef struct packed {
    logic [2:0] bus_sel;
    logic [2:0] alu_op;
    logic ar_we, pc_we, pc_inc, dr_we, ir_we, ac_we;
    logic mem_rd, mem_wr, halted, illegal, bus_err;
  } obs_t;

  obs_t got;
  assign got = {bus_sel, alu_op, ar_we, pc_we, pc_inc, dr_we, ir_we, ac_we,
                mem_rd, mem_wr, halted, illegal, bus_err};

  obs_t  exp_q[$];
  string tag_q[$];
  int    n_vec = 0;
  int    n_bad = 0;
  logic  berr_m = 1'b0;

  function automatic void check(string name, logic [31:0] g, logic [31:0] e);
    n_vec++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, g, e);
    end
  endfunction

  // Monitor: one expected output vector per queued cycle
  initial begin
    obs_t  e;
    string t;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, 32'(got), 32'(e));
      end
    end
  end

  task automatic cyc(input obs_t e, input string t, input logic rdy);
    @(posedge clk);
    #1;
    mem_ready = rdy;
    e.bus_err = berr_m;
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // Memory access lasting 'waits' unacknowledged cycles then one ready cycle, unless the watchdog trips.
  task automatic mem_wait(input int waits, input obs_t base, input obs_t on_ready,
                          input string t, output bit ok);
    ok = 1'b0;
    for (int i = 0; i <= waits; i++) begin
      if (i == waits) begin
        cyc(on_ready, t, 1'b1);
        ok = 1'b1;
        return;
      end
      cyc(base, t, 1'b0);
      if (i == TO - 1) begin
        berr_m = 1'b1;
        return;
      end
    end
  endtask

  task automatic idle_cyc(input int n, input logic rv);
    for (int i = 0; i < n; i++) begin
      cyc('0, "idle", rnd());
      run = rv;
    end
  endtask

  task automatic hlt_cyc(input int n);
    obs_t e;
    e = '0;
    e.halted = 1'b1;
    for (int i = 0; i < n; i++) begin
      cyc(e, "halt", rnd());
      run = 1'b1;
    end
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must clear before the next edge.
  task automatic do_reset(input string t);
    @(negedge clk);
    #1;
    reset = 1'b0;
    run   = 1'b0;
    #1;
    check({t, "_outputs"}, 32'(got), 32'(0));
    check({t, "_state"}, 32'(state_dbg), 32'(0));
    berr_m = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic instr(input logic [3:0] op, input logic az, input int w1, input int w2);
    obs_t  e, r;
    bit    ok;
    string t;
    t = $sformatf("op%0h", op);
    e = '0; e.bus_sel = 3'd1; e.ar_we = 1'b1;
    cyc(e, {t, "_fetch_addr"}, rnd());
    ir_op   = op;
    ac_zero = az;
    e = '0; e.mem_rd = 1'b1;
    r = e; r.dr_we = 1'b1; r.pc_inc = 1'b1;
    mem_wait(w1, e, r, {t, "_fetch_rd"}, ok);
    if (!ok) return;
    e = '0; e.bus_sel = 3'd2; e.ir_we = 1'b1;
    cyc(e, {t, "_load_ir"}, rnd());
    e = '0;
    case (op)
      4'h0, 4'hF: ;
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin e.bus_sel = 3'd4; e.ar_we = 1'b1; end
      4'h6: begin e.bus_sel = 3'd4; e.pc_we = 1'b1; end
      4'h7: begin e.bus_sel = 3'd4; e.pc_we = az; end
      4'h8: begin e.alu_op = 3'd5; e.ac_we = 1'b1; end
      4'h9: begin e.alu_op = 3'd4; e.ac_we = 1'b1; end
      default: e.illegal = 1'b1;
    endcase
    cyc(e, {t, "_decode"}, rnd());
    if (op == 4'h1 || op == 4'h3 || op == 4'h4 || op == 4'h5) begin
      e = '0; e.mem_rd = 1'b1;
      r = e; r.dr_we = 1'b1;
      mem_wait(w2, e, r, {t, "_operand_rd"}, ok);
      if (!ok) return;
      e = '0; e.ac_we = 1'b1;
      e.alu_op = (op == 4'h1) ? 3'd0 : (op == 4'h3) ? 3'd1 : (op == 4'h4) ? 3'd2 : 3'd3;
      cyc(e, {t, "_execute"}, rnd());
    end else if (op == 4'h2) begin
      e = '0; e.bus_sel = 3'd3; e.mem_wr = 1'b1;
      mem_wait(w2, e, e, {t, "_store"}, ok);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    obs_t       e;
    logic [3:0] op;
    int         w1, w2;
    reset = 1'b0; run = 1'b0; ir_op = 4'h0; ac_zero = 1'b0; mem_ready = 1'b0;
    #1;
    check("por_outputs", 32'(got), 32'(0));
    check("por_state", 32'(state_dbg), 32'(0));
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle_cyc(3, 1'b0);
    idle_cyc(1, 1'b1);

    instr(4'h0, 1'b0, 0, 0);
    instr(4'h0, 1'b1, 0, 0);
    instr(4'h1, 1'b0, 2, 2);
    instr(4'h2, 1'b0, 0, 2);
    instr(4'h7, 1'b1, 0, 0);
    instr(4'h7, 1'b0, 0, 0);
    instr(4'hA, 1'b0, 0, 0);
    instr(4'h6, 1'b0, 1, 0);

    for (int k = 0; k < 60; k++) begin
      op = 4'($urandom_range(0, 14));
      w1 = ($urandom_range(0, 7) == 0) ? TO - 1 : int'($urandom_range(0, 3));
      w2 = ($urandom_range(0, 7) == 0) ? TO - 1 : int'($urandom_range(0, 3));
      instr(op, rnd(), w1, w2);
    end

    // Reset while a fetch read is outstanding
    e = '0; e.bus_sel = 3'd1; e.ar_we = 1'b1;
    cyc(e, "pre_reset_fetch_addr", rnd());
    e = '0; e.mem_rd = 1'b1;
    cyc(e, "pre_reset_fetch_rd", 1'b0);
    do_reset("reset_mid_fetch");
    idle_cyc(3, 1'b0);
    idle_cyc(1, 1'b1);

    instr(4'h1, 1'b0, TO + 3, 0);
    hlt_cyc(4);
    do_reset("reset_after_fetch_timeout");
    idle_cyc(1, 1'b1);

    instr(4'h2, 1'b0, 0, TO + 5);
    hlt_cyc(3);
    do_reset("reset_after_store_timeout");
    idle_cyc(1, 1'b1);

    instr(4'h9, 1'b0, 0, 0);
    instr(4'hF, 1'b0, 0, 0);
    hlt_cyc(5);
    do_reset("reset_after_halt");
    idle_cyc(2, 1'b0);

    repeat (2) @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
